img_sobel_3x3: RTL

IMG_SOBEL_3X3 -- requirements
Module: img_sobel_3x3

---
 rtl/img_pkg.sv | 28 ++
 rtl/img_win3x3.sv | 83 ++++++++
 rtl/img_sobel_3x3.sv | 110 +++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared widths, window type and helpers for the 3x3 Sobel edge filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package img_pkg;

  localparam int PIX_W  = 24;
  localparam int GRAY_W = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 12;

  // Magnitudes above this value are clamped before being replicated to RGB.
  localparam logic [MAG_W-1:0] MAG_SAT = 12'd255;

  typedef logic [GRAY_W-1:0]        gray_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;

  // Indexed [row][col]: row 0 is the top (last) line, col 0 is the oldest column.
  typedef gray_t [2:0][2:0] win3x3_t;

  // Absolute value of a gradient; |g| <= 1020 by construction, so no overflow.
  function automatic mag_t grad_abs(grad_t g);
    grad_t pos;
    pos = g[GRAD_W-1] ? -g : g;
    return mag_t'($unsigned(pos));
  endfunction

endpackage

// File: rtl/img_win3x3.sv
// 3x3 gray window shifted per valid column, with column/row position and border flag.
// Latency: 1 cycle from valid_i to a registered window/border/valid_o.
// Backpressure: none; every valid_i beat is accepted, no beat without valid_i.
module img_win3x3
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] last_img_data,
  input  logic [PIX_W-1:0] cur_img_data,
  input  logic [PIX_W-1:0] next_img_data,
  output win3x3_t          win_o,
  output logic             border_o,
  output logic             valid_o
);

  localparam int COL_W = $clog2((IMG_WIDTH  > 1) ? IMG_WIDTH  : 2);
  localparam int ROW_W = $clog2((IMG_HEIGHT > 1) ? IMG_HEIGHT : 2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  win3x3_t          win_q, win_d;
  logic             border_q, border_d;
  logic             vld_q;

  // Upstream replicates gray into all three bytes; only the low byte is used.
  logic unused_hi;
  assign unused_hi = ^{last_img_data[PIX_W-1:GRAY_W],
                       cur_img_data[PIX_W-1:GRAY_W],
                       next_img_data[PIX_W-1:GRAY_W]};

  // Next-state: shift the window, tag the beat's border status, advance position.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    border_d = border_q;
    if (valid_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = last_img_data[GRAY_W-1:0];
      win_d[1][2] = cur_img_data[GRAY_W-1:0];
      win_d[2][2] = next_img_data[GRAY_W-1:0];
      // The window is only fully inside the line from column 2 onward.
      border_d = (col_q < COL_W'(2)) || (row_q == '0) ||
                 (row_q == ROW_W'(IMG_HEIGHT - 1));
      if (col_q == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State registers; reset clears position, window and the in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      win_q    <= '0;
      border_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      win_q    <= win_d;
      border_q <= border_d;
      vld_q    <= valid_i;
    end
  end

  assign win_o    = win_q;
  assign border_o = border_q;
  assign valid_o  = vld_q;

endmodule

// File: rtl/img_sobel_3x3.sv
// Sobel 3x3 edge magnitude (|Gx|+|Gy|, clamped to 255); binary output with IMG_SOBEL_BINARY_EN.
// Latency: 3 cycles valid_i -> valid_o (window reg, gradient reg, output reg).
// Backpressure: none; one valid_o per valid_i, gaps preserved, reset drops in-flight beats.
module img_sobel_3x3
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [PIX_W-1:0]  last_img_data,
  input  logic [PIX_W-1:0]  cur_img_data,
  input  logic [PIX_W-1:0]  next_img_data,
  input  logic [GRAY_W-1:0] threshold,
  output logic [PIX_W-1:0]  img_data_o,
  output logic              valid_o
);

  win3x3_t win;
  logic    win_vld;
  logic    win_border;

  img_win3x3 #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_win (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .last_img_data(last_img_data),
    .cur_img_data (cur_img_data),
    .next_img_data(next_img_data),
    .win_o        (win),
    .border_o     (win_border),
    .valid_o      (win_vld)
  );

  grad_t gx_d, gy_d;
  grad_t gx_q, gy_q;
  logic  border2_q;
  logic  vld2_q;

  // Gradient kernels: Gx = right column minus left, Gy = bottom row minus top.
  always_comb begin
    gx_d = (grad_t'(win[0][2]) + (grad_t'(win[1][2]) <<< 1) + grad_t'(win[2][2]))
         - (grad_t'(win[0][0]) + (grad_t'(win[1][0]) <<< 1) + grad_t'(win[2][0]));
    gy_d = (grad_t'(win[2][0]) + (grad_t'(win[2][1]) <<< 1) + grad_t'(win[2][2]))
         - (grad_t'(win[0][0]) + (grad_t'(win[0][1]) <<< 1) + grad_t'(win[0][2]));
  end

  // Gradient stage register, loaded only for real beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      gx_q      <= '0;
      gy_q      <= '0;
      border2_q <= 1'b0;
      vld2_q    <= 1'b0;
    end else begin
      vld2_q <= win_vld;
      if (win_vld) begin
        gx_q      <= gx_d;
        gy_q      <= gy_d;
        border2_q <= win_border;
      end
    end
  end

  mag_t             mag;
  logic [PIX_W-1:0] pix_d;
  logic [PIX_W-1:0] pix_q;
  logic             vld3_q;

`ifdef IMG_SOBEL_BINARY_EN
  // Binarise against the threshold seen in this cycle; borders are forced low.
  always_comb begin
    mag   = grad_abs(gx_q) + grad_abs(gy_q);
    pix_d = (mag >= MAG_W'(threshold)) ? {PIX_W{1'b1}} : '0;
    if (border2_q) pix_d = '0;
  end
`else
  logic [GRAY_W-1:0] sat;
  logic              unused_thr;
  assign unused_thr = ^threshold;

  // Clamp the magnitude to 8 bits and replicate to gray RGB; borders are forced low.
  always_comb begin
    mag   = grad_abs(gx_q) + grad_abs(gy_q);
    sat   = (mag > MAG_SAT) ? MAG_SAT[GRAY_W-1:0] : mag[GRAY_W-1:0];
    pix_d = {sat, sat, sat};
    if (border2_q) pix_d = '0;
  end
`endif

  // Output stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q  <= '0;
      vld3_q <= 1'b0;
    end else begin
      vld3_q <= vld2_q;
      if (vld2_q) pix_q <= pix_d;
    end
  end

  assign img_data_o = pix_q;
  assign valid_o    = vld3_q;

endmodule
